// File: rtl/cordic_pkg.sv
// cordic_pkg: shared Q2.20 widths, arctan table, gain constant and FSM states
// for the iterative vectoring CORDIC (CORDIC_MAG_COMP_EN adds gain correction).
package cordic_pkg;

  localparam int CORDIC_W     = 22;
  localparam int CORDIC_FRAC  = 20;
  localparam int CORDIC_INT_W = 25;
  localparam int MAG_W        = CORDIC_INT_W + CORDIC_FRAC + 1;

  localparam logic [CORDIC_W-1:0] ATAN_TABLE [0:15] = '{
    22'd823550, 22'd486170, 22'd256879, 22'd130396,
    22'd65451,  22'd32757,  22'd16383,  22'd8192,
    22'd4096,   22'd2048,   22'd1024,   22'd512,
    22'd256,    22'd128,    22'd64,     22'd32
  };

  localparam logic [CORDIC_FRAC-1:0] K_INV = 20'd636750;

  localparam logic [CORDIC_W-1:0] MAG_MAX = 22'h1FFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    COMP
  } cordic_state_e;

  // Clamp a wide signed magnitude into [0, MAG_MAX].
  function automatic logic [CORDIC_W-1:0] sat_mag(
    input logic signed [MAG_W-1:0] v
  );
    logic [CORDIC_W-1:0] r;
    if (v[MAG_W-1])
      r = '0;
    else if (v > $signed({{(MAG_W-CORDIC_W){1'b0}}, MAG_MAX}))
      r = MAG_MAX;
    else
      r = v[CORDIC_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation,
// steering y toward zero and accumulating the rotated angle in z.
module cordic_vec_stage
  import cordic_pkg::*;
(
  input  logic signed [CORDIC_INT_W-1:0] x_i,
  input  logic signed [CORDIC_INT_W-1:0] y_i,
  input  logic signed [CORDIC_W-1:0]     z_i,
  input  logic [3:0]                     shift_i,
  input  logic signed [CORDIC_W-1:0]     atan_i,
  output logic signed [CORDIC_INT_W-1:0] x_o,
  output logic signed [CORDIC_INT_W-1:0] y_o,
  output logic signed [CORDIC_W-1:0]     z_o
);

  logic signed [CORDIC_INT_W-1:0] xs;
  logic signed [CORDIC_INT_W-1:0] ys;
  logic                           d;

  assign xs = x_i >>> shift_i;
  assign ys = y_i >>> shift_i;
  assign d  = y_i[CORDIC_INT_W-1];

  always_comb begin
    if (d) begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - atan_i;
    end else begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring CORDIC returning atan(y/x) and magnitude.
// Define CORDIC_MAG_COMP_EN to add a COMP cycle that removes the CORDIC gain.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CORDIC_W-1:0] x_in,
  input  logic [CORDIC_W-1:0] y_in,
  output logic [CORDIC_W-1:0] angle_out,
  output logic [CORDIC_W-1:0] mag_out,
  output logic                quad_flip,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] LAST = 4'(ITERATIONS - 1);

  cordic_state_e state_q, state_d;

  logic signed [CORDIC_INT_W-1:0] x_q, x_d;
  logic signed [CORDIC_INT_W-1:0] y_q, y_d;
  logic signed [CORDIC_W-1:0]     z_q, z_d;
  logic [3:0]                     i_q, i_d;
  logic                           zero_q, zero_d;
  logic                           flip_q, flip_d;

  logic [CORDIC_W-1:0] angle_q, angle_d;
  logic [CORDIC_W-1:0] mag_q, mag_d;
  logic                qf_q, qf_d;
  logic                done_q, done_d;

  logic signed [CORDIC_INT_W-1:0] x_nx;
  logic signed [CORDIC_INT_W-1:0] y_nx;
  logic signed [CORDIC_W-1:0]     z_nx;

  logic signed [CORDIC_INT_W-1:0] xin_s;
  logic signed [CORDIC_INT_W-1:0] yin_s;

  logic                       wr;
  logic signed [CORDIC_W-1:0] wr_z;
  logic signed [MAG_W-1:0]    wr_v;

  assign xin_s = {{(CORDIC_INT_W-CORDIC_W){x_in[CORDIC_W-1]}}, x_in};
  assign yin_s = {{(CORDIC_INT_W-CORDIC_W){y_in[CORDIC_W-1]}}, y_in};

  cordic_vec_stage u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (i_q),
    .atan_i  (ATAN_TABLE[i_q]),
    .x_o     (x_nx),
    .y_o     (y_nx),
    .z_o     (z_nx)
  );

`ifdef CORDIC_MAG_COMP_EN
  logic signed [MAG_W-1:0] prod;

  assign prod = MAG_W'(x_q) * MAG_W'($signed({1'b0, K_INV}));
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    zero_d  = zero_q;
    flip_d  = flip_q;
    angle_d = angle_q;
    mag_d   = mag_q;
    qf_d    = qf_q;
    done_d  = 1'b0;
    wr      = 1'b0;
    wr_z    = z_q;
    wr_v    = MAG_W'(x_q);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ITER;
          // Fold the left half-plane onto the right one.
          x_d     = x_in[CORDIC_W-1] ? -xin_s : xin_s;
          y_d     = x_in[CORDIC_W-1] ? -yin_s : yin_s;
          z_d     = '0;
          i_d     = '0;
          flip_d  = x_in[CORDIC_W-1];
          zero_d  = (x_in == '0) && (y_in == '0);
        end
      end
      ITER: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        i_d = i_q + 4'd1;
        if (i_q == LAST) begin
`ifdef CORDIC_MAG_COMP_EN
          state_d = COMP;
`else
          state_d = IDLE;
          wr      = 1'b1;
          wr_z    = z_nx;
          wr_v    = MAG_W'(x_nx);
`endif
        end
      end
      COMP: begin
        state_d = IDLE;
`ifdef CORDIC_MAG_COMP_EN
        wr      = 1'b1;
        wr_z    = z_q;
        wr_v    = prod >>> CORDIC_FRAC;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (wr) begin
      angle_d = zero_q ? '0 : wr_z;
      mag_d   = zero_q ? '0 : sat_mag(wr_v);
      qf_d    = flip_q;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      flip_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
      qf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      zero_q  <= zero_d;
      flip_q  <= flip_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
      qf_q    <= qf_d;
      done_q  <= done_d;
    end
  end

  assign angle_out = angle_q;
  assign mag_out   = mag_q;
  assign quad_flip = qf_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: scoreboard bench for the vectoring CORDIC; expected
// angle/magnitude come from real-valued atan/sqrt with a +-64 LSB tolerance.
module tb_cordic_vectoring;

`ifdef CORDIC_MAG_COMP_EN
  localparam int  LAT = 17;
  localparam real KM  = 1.6467602581 * 636750.0 / 1048576.0;
`else
  localparam int  LAT = 16;
  localparam real KM  = 1.6467602581;
`endif
  localparam int  TOL = 64;
  localparam real PI  = 3.14159265358979;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [21:0] x_in = '0;
  logic [21:0] y_in = '0;
  logic [21:0] angle_out;
  logic [21:0] mag_out;
  logic        quad_flip;
  logic        busy;
  logic        done;

  typedef struct {
    int ang;
    int mag;
    bit flip;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  cordic_vectoring #(.ITERATIONS(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .angle_out (angle_out),
    .mag_out   (mag_out),
    .quad_flip (quad_flip),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    real a, m;
    if (x == 0 && y == 0) a = 0.0;
    else if (x == 0) a = (y > 0) ? PI / 2.0 : -PI / 2.0;
    else a = $atan(real'(y) / real'(x));
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * KM;
    e.ang  = int'(a * 1048576.0);
    e.mag  = (m > 2097151.0) ? 2097151 : int'(m);
    e.flip = (x < 0);
    e.cyc  = 0;
    return e;
  endfunction

  task automatic drive(input int x, input int y);
    exp_t e;
    @(negedge clk);
    x_in  = x[21:0];
    y_in  = y[21:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(x, y);
    e.cyc = cyc + LAT;
    sb.push_back(e);
  endtask

  task automatic wait_done(output bit got, output int dc);
    got = 1'b0;
    dc  = -1;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        dc  = cyc;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (angle_out !== 22'd0) begin
      failures++;
      $display("FAIL reset_angle: got %0d want 0", angle_out);
    end
    checks++;
    if (mag_out !== 22'd0) begin
      failures++;
      $display("FAIL reset_mag: got %0d want 0", mag_out);
    end
    checks++;
    if (quad_flip !== 1'b0) begin
      failures++;
      $display("FAIL reset_flip: got %b want 0", quad_flip);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    reset = 1'b0;
  endtask

  task automatic test_vec(input string name, input int x, input int y);
    exp_t e;
    bit   got;
    int   dc, diff;
    drive(x, y);
    wait_done(got, dc);
    e = sb.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s_timeout: no done, want done at cycle %0d", name, e.cyc);
      return;
    end
    if (dc !== e.cyc) begin
      failures++;
      $display("FAIL %s_latency: done at cycle %0d want %0d", name, dc, e.cyc);
    end
    checks++;
    diff = int'($signed(angle_out)) - e.ang;
    if (diff > TOL || diff < -TOL) begin
      failures++;
      $display("FAIL %s_angle: got %0d want %0d", name, $signed(angle_out), e.ang);
    end
    checks++;
    diff = int'(mag_out) - e.mag;
    if (diff > TOL || diff < -TOL) begin
      failures++;
      $display("FAIL %s_mag: got %0d want %0d", name, mag_out, e.mag);
    end
    checks++;
    if (quad_flip !== e.flip) begin
      failures++;
      $display("FAIL %s_flip: got %b want %b", name, quad_flip, e.flip);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit   got;
    int   e0, n, dc, diff;
    @(negedge clk);
    x_in  = 22'd300000;
    y_in  = 22'd200000;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e = model(300000, 200000);
      e.cyc = e0 + LAT + k * (LAT + 1);
      sb.push_back(e);
    end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        n++;
        e = sb.pop_front();
        checks++;
        if (cyc !== e.cyc) begin
          failures++;
          $display("FAIL b2b_latency: done at cycle %0d want %0d", cyc, e.cyc);
        end
        checks++;
        diff = int'($signed(angle_out)) - e.ang;
        if (diff > TOL || diff < -TOL) begin
          failures++;
          $display("FAIL b2b_angle: got %0d want %0d", $signed(angle_out), e.ang);
        end
      end
    end
    start = 1'b0;
    checks++;
    if (n !== 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d results want 2", n);
    end
    wait_done(got, dc);
    while (sb.size() > 1) void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (!got || dc !== e.cyc) begin
      failures++;
      $display("FAIL b2b_third: done at cycle %0d want %0d", dc, e.cyc);
    end
  endtask

  task automatic test_busy_start;
    exp_t e;
    bit   got;
    int   dc, diff, n;
    drive(400000, -300000);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_high: got %b want 1", busy);
    end
    x_in  = 22'd100000;
    y_in  = 22'd500000;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(got, dc);
    e = sb.pop_front();
    checks++;
    if (!got || dc !== e.cyc) begin
      failures++;
      $display("FAIL busy_latency: done at cycle %0d want %0d", dc, e.cyc);
    end
    checks++;
    diff = int'($signed(angle_out)) - e.ang;
    if (diff > TOL || diff < -TOL) begin
      failures++;
      $display("FAIL busy_angle: got %0d want %0d", $signed(angle_out), e.ang);
    end
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL busy_extra_done: got %0d extra results want 0", n);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    drive(500000, 250000);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (angle_out !== 22'd0 || mag_out !== 22'd0) begin
      failures++;
      $display("FAIL midreset_data: got angle %0d mag %0d want 0 0", angle_out, mag_out);
    end
    checks++;
    if (quad_flip !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ctrl: got flip %b busy %b done %b want 0 0 0",
               quad_flip, busy, done);
    end
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n++;
    end
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL midreset_done: got %0d results want 0", n);
    end
    test_vec("after_reset", 500000, 250000);
  endtask

  initial begin
    test_reset();
    test_vec("x_axis", 524288, 0);
    test_vec("diag", 262144, 262144);
    test_vec("pos_y_axis", 0, 524288);
    test_vec("neg_y_axis", 0, -524288);
    test_vec("quad_flip", -262144, 262144);
    test_vec("no_flip", 262144, -262144);
    test_vec("zero", 0, 0);
    test_vec("saturate", 2097151, 2097151);
    test_vec("left_half", -500000, -100000);
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
